wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone (classic) arbiter directly downstream of the core.
- The core's instruction port and data port both feed it; it produces the single memory-side bus for unified RAM.
- Arbitration is round-robin with a registered grant, and the grant is locked for the whole cycle (cyc held).
- A per-access watchdog returns err to a master whose slave never acknowledges.

Parameters:
ADR_W, 30, address width (word address, byte bits [1:0] dropped)
DAT_W, 32, data width
SEL_W, DAT_W/8, byte-select width
TIMEOUT, 255, max cycles stb may wait for ack/err before forced err; 0 disables watchdog

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
m0_cyc  input  1  master 0 (data port) cycle
m0_stb  input  1  master 0 strobe
m0_we  input  1  master 0 write enable
m0_adr  input  ADR_W  master 0 address
m0_dat_w  input  DAT_W  master 0 write data
m0_sel  input  SEL_W  master 0 byte select
m0_dat_r  output  DAT_W  master 0 read data
m0_ack  output  1  master 0 acknowledge
m0_err  output  1  master 0 error
m1_cyc/m1_stb/m1_we/m1_adr/m1_dat_w/m1_sel/m1_dat_r/m1_ack/m1_err  same directions and widths as m0_*; master 1 (instruction port)
s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel  output  1/1/1/ADR_W/DAT_W/SEL_W  slave-side request
s_dat_r  input  DAT_W  slave read data
s_ack  input  1  slave acknowledge
s_err  input  1  slave error
gnt  output  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle

Behaviour:
- State machine: IDLE, GNT0, GNT1. The state register and last_gnt register are the only control state, plus the watchdog counter.
- Reset (rst high at clk edge):
  - state=IDLE, last_gnt=1 (so m0 wins the first tie), watchdog=0.
  - All outputs derive from state, so after reset: s_cyc=s_stb=0, gnt=00, m*_ack=m*_err=0.
  - Reset mid-transaction aborts it; no ack is forwarded in the reset cycle or after.
- IDLE transitions:
  - only m0_cyc -> GNT0.
  - only m1_cyc -> GNT1.
  - both -> grant the master != last_gnt.
  - neither -> stay in IDLE.
- Arbitration latency: grant is registered. The slave sees the request one cycle after cyc first rises in IDLE.
- GNTn:
  - Hold while mn_cyc=1; the grant is locked across back-to-back/multi-beat accesses.
  - mn_cyc=0 -> IDLE and last_gnt<=n.
  - No direct GNT0->GNT1 hop; the other master re-arbitrates from IDLE, giving a 1-cycle bubble.
- Routing (combinational, in GNTn only):
  - s_cyc=mn_cyc, s_stb=mn_stb.
  - s_we, s_adr, s_dat_w and s_sel come from mn.
  - mn_ack=s_ack & s_stb and mn_err=(s_err & s_stb) | wd_err.
  - The ungranted master sees ack=err=0.
  - m*_dat_r = s_dat_r to both masters (don't-care without ack).
  - In IDLE: s_cyc=s_stb=0, and s_we/s_adr/s_dat_w/s_sel=0.
- Watchdog (TIMEOUT>0):
  - Counter increments each cycle s_stb=1 with s_ack=s_err=0.
  - It clears on ack, err, stb low, or state change.
  - When counter==TIMEOUT-1 and still no ack/err: wd_err pulses for 1 cycle to the granted master, s_stb and s_cyc are masked low that cycle, and the counter clears.
  - Grant is kept; the master decides whether to drop cyc.
- Simultaneous s_ack and watchdog expiry: ack wins, no wd_err.
- s_ack/s_err arriving while IDLE is ignored, with no output to either master.
- Widths: no arithmetic except the watchdog counter, sized $clog2(TIMEOUT+1), saturating never needed (cleared at expiry).

Test Plan:
- Reset then m0 single read: m0_cyc=m0_stb=1, adr=0x100; slave acks 2 cycles after s_stb -> s_stb rises 1 cycle after m0_cyc; m0_ack=1 once with m0_dat_r=s_dat_r=0xDEADBEEF; gnt=01; m1_ack=0 throughout.
- Simultaneous request from reset: m0 and m1 assert cyc in the same cycle -> gnt=01 first. After m0 drops cyc: IDLE 1 cycle, then gnt=10. Next tie -> gnt=01 (round-robin alternates).
- Grant lock: m1 holds cyc for 4 back-to-back stb/ack beats while m0 requests -> all 4 beats go to m1 with gnt=10 unchanged; m0 granted only after m1_cyc=0.
- Watchdog: TIMEOUT=4, m0 write to a slave that never acks -> s_stb high 3 cycles, then 4th cycle s_stb=0 and m0_err=1 for exactly 1 cycle; m0_ack never asserted.
- Reset mid-access: rst pulsed while GNT1 with s_stb=1 and s_ack arriving same cycle -> next cycle gnt=00, s_cyc=s_stb=0, m1_ack=0.
- Slave error pass-through: s_err=1 during m1 read -> m1_err=1 in that cycle, m1_ack=0, m0_err=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter.
//
// Sits between the core's data port (m0) and instruction port (m1) and the single memory-side
// bus to unified RAM. Arbitration is round-robin with a registered grant. Once granted, a master
// keeps the bus for as long as it holds cyc. A per-access watchdog returns err to the granted
// master if the slave leaves a strobe unanswered for TIMEOUT cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_* (data port)         cyc/stb/we/adr/dat_w/sel in, dat_r/ack/err out
//   m1_* (instruction port)  same as m0_*
//   s_*                      slave-side request out, dat_r/ack/err in
//   gnt                      one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle
module wb_arbiter #(
    parameter int unsigned ADR_W   = 30,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned SEL_W   = DAT_W / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_w,
    input  logic [SEL_W-1:0] m0_sel,
    output logic [DAT_W-1:0] m0_dat_r,
    output logic             m0_ack,
    output logic             m0_err,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_w,
    input  logic [SEL_W-1:0] m1_sel,
    output logic [DAT_W-1:0] m1_dat_r,
    output logic             m1_ack,
    output logic             m1_err,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_w,
    output logic [SEL_W-1:0] s_sel,
    input  logic [DAT_W-1:0] s_dat_r,
    input  logic             s_ack,
    input  logic             s_err,

    output logic [1:0]       gnt
);

    // Counter is one bit wide even when the watchdog is disabled, to keep the vector legal.
    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] WdLast = (TIMEOUT > 0) ? WdW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;   // 0: m0 was served last, 1: m1
    logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;

    logic             gnt0, gnt1;
    logic             req_cyc, req_stb;
    logic             wd_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;                 // m0 wins the first tie
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_gnt_q ? StGnt0 : StGnt1;
                end else if (m0_cyc) begin
                    state_d = StGnt0;
                end else if (m1_cyc) begin
                    state_d = StGnt1;
                end
            end
            // Grant is locked until the owner drops cyc; the other master always re-arbitrates
            // through StIdle.
            StGnt0: begin
                if (!m0_cyc) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b0;
                end
            end
            StGnt1: begin
                if (!m1_cyc) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and routing
    always_comb begin
        // Qualifying with rst drops any response arriving in the reset cycle itself.
        gnt0    = (state_q == StGnt0) && !rst;
        gnt1    = (state_q == StGnt1) && !rst;
        gnt     = {gnt1, gnt0};

        req_cyc = 1'b0;
        req_stb = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        if (gnt0) begin
            req_cyc = m0_cyc;
            req_stb = m0_stb;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_dat_w = m0_dat_w;
            s_sel   = m0_sel;
        end else if (gnt1) begin
            req_cyc = m1_cyc;
            req_stb = m1_stb;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_dat_w = m1_dat_w;
            s_sel   = m1_sel;
        end

        // A real ack or err in the expiry cycle takes precedence over the timeout.
        wd_err = (TIMEOUT != 0) && req_stb && !s_ack && !s_err && (wd_cnt_q == WdLast);

        // The request is withdrawn from the slave during the timeout cycle.
        s_cyc = req_cyc & ~wd_err;
        s_stb = req_stb & ~wd_err;

        m0_ack   = gnt0 & s_ack & s_stb;
        m1_ack   = gnt1 & s_ack & s_stb;
        m0_err   = gnt0 & ((s_err & s_stb) | wd_err);
        m1_err   = gnt1 & ((s_err & s_stb) | wd_err);
        m0_dat_r = s_dat_r;
        m1_dat_r = s_dat_r;
    end

    // Watchdog counts consecutive unanswered strobe cycles of the current grant.
    always_comb begin
        if ((TIMEOUT == 0) || (state_d != state_q) || !req_stb || s_ack || s_err || wd_err) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int unsigned ADR_W   = 30;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             m0_cyc, m0_stb, m0_we;
    logic [ADR_W-1:0] m0_adr;
    logic [DAT_W-1:0] m0_dat_w, m0_dat_r;
    logic [SEL_W-1:0] m0_sel;
    logic             m0_ack, m0_err;
    logic             m1_cyc, m1_stb, m1_we;
    logic [ADR_W-1:0] m1_adr;
    logic [DAT_W-1:0] m1_dat_w, m1_dat_r;
    logic [SEL_W-1:0] m1_sel;
    logic             m1_ack, m1_err;
    logic             s_cyc, s_stb, s_we;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_w, s_dat_r;
    logic [SEL_W-1:0] s_sel;
    logic             s_ack, s_err;
    logic [1:0]       gnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .ADR_W   (ADR_W),
        .DAT_W   (DAT_W),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_dat_w (m0_dat_w),
        .m0_sel   (m0_sel),
        .m0_dat_r (m0_dat_r),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_dat_w (m1_dat_w),
        .m1_sel   (m1_sel),
        .m1_dat_r (m1_dat_r),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_sel    (s_sel),
        .s_dat_r  (s_dat_r),
        .s_ack    (s_ack),
        .s_err    (s_err),
        .gnt      (gnt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
        s_dat_r = '0; s_ack = 0; s_err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        settle();
    endtask

    initial begin
        do_reset();

        // Reset state
        check_val("rst_gnt", gnt, 2'b00);
        check_val("rst_s_cyc", s_cyc, 1'b0);
        check_val("rst_s_stb", s_stb, 1'b0);
        check_val("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);

        // m0 single read, slave acks two cycles after s_stb rises
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h100; m0_sel = 4'hF;
        settle();
        check_val("rd_idle_stb", s_stb, 1'b0);
        step(); settle();
        check_val("rd_gnt", gnt, 2'b01);
        check_val("rd_s_stb", s_stb, 1'b1);
        check_val("rd_s_adr", s_adr, 30'h100);
        check_val("rd_ack_early", m0_ack, 1'b0);
        step(); settle();
        check_val("rd_ack_wait", m0_ack, 1'b0);
        step();
        s_ack = 1; s_dat_r = 32'hDEADBEEF;
        settle();
        check_val("rd_m0_ack", m0_ack, 1'b1);
        check_val("rd_m0_dat", m0_dat_r, 32'hDEADBEEF);
        check_val("rd_m1_ack", m1_ack, 1'b0);
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        settle();
        check_val("rd_ack_drop", m0_ack, 1'b0);
        step(); settle();
        check_val("rd_back_idle", gnt, 2'b00);

        // Simultaneous request from reset: m0 first
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h10;
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h20;
        step(); settle();
        check_val("tie1_gnt", gnt, 2'b01);
        s_ack = 1;
        settle();
        check_val("tie1_m0_ack", m0_ack, 1'b1);
        check_val("tie1_m1_ack", m1_ack, 1'b0);
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        settle();
        check_val("tie1_hold", gnt, 2'b01);
        step(); settle();
        check_val("tie1_bubble", gnt, 2'b00);
        step(); settle();
        check_val("tie1_m1_gnt", gnt, 2'b10);
        check_val("tie1_m1_adr", s_adr, 30'h20);

        // Grant lock: 4 beats for m1 while m0 requests
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h55;
        for (int i = 0; i < 4; i++) begin
            m1_adr = 30'(32'h200 + i);
            s_ack = 1;
            settle();
            check_val($sformatf("lock_gnt%0d", i), gnt, 2'b10);
            check_val($sformatf("lock_adr%0d", i), s_adr, 30'(32'h200 + i));
            check_val($sformatf("lock_ack%0d", i), {m1_ack, m0_ack}, 2'b10);
            step();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        settle();
        check_val("lock_last", gnt, 2'b10);
        step();
        // Re-request from m1 in the bubble: tie after m1 was served goes to m0
        m1_cyc = 1; m1_stb = 1;
        settle();
        check_val("lock_bubble", gnt, 2'b00);
        step(); settle();
        check_val("tie2_gnt", gnt, 2'b01);
        check_val("tie2_adr", s_adr, 30'h55);
        s_ack = 1;
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step(); step(); settle();
        check_val("tie2_m1_next", gnt, 2'b10);
        m1_cyc = 0; m1_stb = 0;
        step(); step();

        // Watchdog: write to a slave that never acks
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 30'h3C; m0_dat_w = 32'hCAFE0001;
        m0_sel = 4'h3;
        step(); settle();
        check_val("wd_we", s_we, 1'b1);
        check_val("wd_dat_w", s_dat_w, 32'hCAFE0001);
        check_val("wd_sel", s_sel, 4'h3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("wd_stb%0d", i), {s_cyc, s_stb, m0_err, m0_ack}, 4'b1100);
            step(); settle();
        end
        check_val("wd_expire", {s_cyc, s_stb, m0_err, m0_ack}, 4'b0010);
        check_val("wd_gnt_kept", gnt, 2'b01);
        step(); settle();
        check_val("wd_err_once", {s_stb, m0_err}, 2'b10);
        step(); step(); step();
        // Counter now at its last value: a real ack wins
        s_ack = 1;
        settle();
        check_val("wd_ack_wins", {s_stb, m0_ack, m0_err}, 3'b110);
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        step(); step();

        // Reset mid-access during GNT1 with ack arriving
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h77;
        step(); settle();
        check_val("mid_gnt", gnt, 2'b10);
        rst = 1; s_ack = 1;
        settle();
        check_val("mid_rst_ack", m1_ack, 1'b0);
        step();
        rst = 0;
        settle();
        check_val("mid_after_gnt", gnt, 2'b00);
        check_val("mid_after_s", {s_cyc, s_stb}, 2'b00);
        check_val("mid_idle_ack", {m1_ack, m0_ack}, 2'b00);
        s_ack = 0; s_err = 1;
        settle();
        check_val("idle_err_ign", {m1_err, m0_err}, 2'b00);
        s_err = 0;

        // Slave error pass-through on m1 read
        step(); settle();
        check_val("serr_gnt", gnt, 2'b10);
        s_err = 1;
        settle();
        check_val("serr_m1", {m1_err, m1_ack, m0_err}, 3'b100);
        step();
        s_err = 0; m1_cyc = 0; m1_stb = 0;
        step(); settle();
        check_val("serr_idle", gnt, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
